// File: rtl/test1.sv
// Free-running baud-rate tick generator: BaudTick at the baud rate from a rounded clock divisor.
// Define BAUD_OVERSAMPLE_EN to add a 16x BaudTick16 output; BaudTick is then derived from it.
module test1 #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic reset,
  output logic BaudTick
`ifdef BAUD_OVERSAMPLE_EN
  ,
  output logic BaudTick16
`endif
);

`ifdef BAUD_OVERSAMPLE_EN

  localparam int unsigned OS_RAW = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int unsigned OS_DIV = (OS_RAW < 2) ? 2 : OS_RAW;
  localparam int unsigned OS_W   = $clog2(OS_DIV);
  localparam int unsigned SUB_W  = 4;
  localparam logic [OS_W-1:0]  OS_MAX  = OS_W'(OS_DIV - 1);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(15);

  logic [OS_W-1:0]  r_os_cnt;
  logic [SUB_W-1:0] r_sub_cnt;
  logic             r_tick16;
  logic             r_tick;
  logic             w_os_wrap;

  assign w_os_wrap = (r_os_cnt == OS_MAX);

  // 16x divider; every 16th oversample tick also produces the baud tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_os_cnt  <= '0;
      r_sub_cnt <= '0;
      r_tick16  <= 1'b0;
      r_tick    <= 1'b0;
    end else if (w_os_wrap) begin
      r_os_cnt  <= '0;
      r_sub_cnt <= r_sub_cnt + SUB_W'(1);
      r_tick16  <= 1'b1;
      r_tick    <= (r_sub_cnt == SUB_MAX);
    end else begin
      r_os_cnt  <= r_os_cnt + OS_W'(1);
      r_tick16  <= 1'b0;
      r_tick    <= 1'b0;
    end
  end

  assign BaudTick16 = r_tick16;
  assign BaudTick   = r_tick;

`else

  localparam int unsigned DIV_RAW = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned DIVISOR = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int unsigned CNT_W   = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_MAX);

  // Divide-by-DIVISOR counter; the tick is registered alongside the wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign BaudTick = r_tick;

`endif

endmodule

// File: tb/tb_test1.sv
// Directed bench for test1: divisor 4, clamped divisor 2 and default rate, plus the 16x build.
module tb_test1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0d: got %0b expected %0b", name, idx, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

`ifdef BAUD_OVERSAMPLE_EN

  logic t_os, t16_os;

  test1 #(.CLK_FREQ(320), .BAUD_RATE(2)) u_os (
    .clk(clk), .reset(reset), .BaudTick(t_os), .BaudTick16(t16_os)
  );

  initial begin
    reset = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      check("os_reset_tick", 0, t_os, 1'b0);
      check("os_reset_tick16", 0, t16_os, 1'b0);
    end
    @(negedge clk) reset = 1'b0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk); #1;
      check("os_tick16", e, t16_os, (e % 10) == 0);
      check("os_tick", e, t_os, (e % 160) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

`else

  logic t_d4, t_d2, t_def;

  test1 #(.CLK_FREQ(8), .BAUD_RATE(2)) u_d4 (
    .clk(clk), .reset(reset), .BaudTick(t_d4)
  );
  test1 #(.CLK_FREQ(1), .BAUD_RATE(2)) u_d2 (
    .clk(clk), .reset(reset), .BaudTick(t_d2)
  );
  test1 u_def (
    .clk(clk), .reset(reset), .BaudTick(t_def)
  );

  typedef struct {
    logic rst;
    logic e4;
    logic e2;
    logic edef;
  } vec_t;

  vec_t tbl[$];

  initial begin
    string rst_s, d4_s, d2_s;
    int    pulses_def, pulses_d4, pulses_d2;
    int    edges_def[$];
    logic  prev_d4, prev_d2, prev_def;

    // Phases: clean start, reset mid-count at edge 6, reset on a wrap edge
    rst_s = "11000000000000100000100000000100010000";
    d4_s  = "00000100010001000010000010001000000001";
    d2_s  = "00010101010101001010001010101001000101";
    for (int i = 0; i < rst_s.len(); i++)
      tbl.push_back('{rst: rst_s[i] == "1", e4: d4_s[i] == "1",
                      e2: d2_s[i] == "1", edef: 1'b0});
    // Long reset hold: nothing may pulse
    for (int i = 0; i < 50; i++)
      tbl.push_back('{rst: 1'b1, e4: 1'b0, e2: 1'b0, edef: 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk) reset = tbl[i].rst;
      @(posedge clk); #1;
      check("d4_tick", i, t_d4, tbl[i].e4);
      check("d2_tick", i, t_d2, tbl[i].e2);
      check("def_tick", i, t_def, tbl[i].edef);
    end

    // Free run of 2000 edges from reset release
    @(negedge clk) reset = 1'b0;
    pulses_def = 0; pulses_d4 = 0; pulses_d2 = 0;
    prev_d4 = 1'b0; prev_d2 = 1'b0; prev_def = 1'b0;
    for (int e = 1; e <= 2000; e++) begin
      @(posedge clk); #1;
      if (t_def) begin
        pulses_def++;
        edges_def.push_back(e);
      end
      if (t_d4) pulses_d4++;
      if (t_d2) pulses_d2++;
      if (t_d4 && prev_d4) check("d4_back_to_back", e, t_d4, 1'b0);
      if (t_d2 && prev_d2) check("d2_back_to_back", e, t_d2, 1'b0);
      if (t_def && prev_def) check("def_back_to_back", e, t_def, 1'b0);
      prev_d4 = t_d4; prev_d2 = t_d2; prev_def = t_def;
    end
    check_int("def_pulse_count", pulses_def, 4);
    check_int("d4_pulse_count", pulses_d4, 500);
    check_int("d2_pulse_count", pulses_d2, 1000);
    for (int k = 0; k < 4; k++)
      check_int($sformatf("def_pulse_edge_%0d", k),
                (k < edges_def.size()) ? edges_def[k] : -1, 434 * (k + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

`endif

endmodule
